// File: rtl/chess_board_scanner.sv
// Scans an 8x8 key matrix row by row and debounces whole frames into one confirmed move (build macro SCANNER_MULTI_ERR_EN adds multi-press rejection).
// Latency: temJogada rises one clock after the frame_end edge of the DEBOUNCE-th matching frame.
// No backpressure: temJogada is a single-cycle strobe and coordinates hold until the next move.
module chess_board_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] colunas,
  output logic [7:0] linha_sel,
  output logic [3:0] jogadaFileira,
  output logic [3:0] jogadaColuna,
  output logic       temJogada,
`ifdef SCANNER_MULTI_ERR_EN
  output logic       erro_multipla,
`endif
  output logic [3:0] db_estado
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    CONFIRM  = 2'd1,
    EMIT     = 2'd2,
    WAIT_REL = 2'd3
  } stateT;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB      = 4'(DEBOUNCE);

  logic [7:0]  colunasMeta;
  logic [7:0]  colunas_s;
  logic [15:0] divCnt;
  logic [2:0]  rowCnt;
  logic        sampleTick;
  logic        frameEnd;
  logic        anyAcc;
  logic [5:0]  selAcc;
  logic        rowHit;
  logic        anyNow;
  logic [5:0]  selNow;
  logic        anyEff;
  stateT       state, stateNext;
  logic [5:0]  cand, candNext;
  logic [3:0]  cnt, cntNext;
  logic [3:0]  cntInc;

  function automatic logic [2:0] lowestCol(input logic [7:0] v);
    lowestCol = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowestCol = 3'(i);
    end
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      colunasMeta <= 8'd0;
      colunas_s   <= 8'd0;
    end else begin
      colunasMeta <= colunas;
      colunas_s   <= colunasMeta;
    end
  end

  assign sampleTick = (divCnt == DIV_LAST);
  assign frameEnd   = sampleTick && (rowCnt == 3'd7);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divCnt    <= 16'd0;
      rowCnt    <= 3'd0;
      linha_sel <= 8'h01;
    end else if (sampleTick) begin
      divCnt    <= 16'd0;
      rowCnt    <= rowCnt + 3'd1;
      linha_sel <= {linha_sel[6:0], linha_sel[7]};
    end else begin
      divCnt <= divCnt + 16'd1;
    end
  end

  // Frame verdict including the row being sampled this cycle; the first hit in scan order wins.
  assign rowHit = |colunas_s;
  assign anyNow = anyAcc | rowHit;
  assign selNow = anyAcc ? selAcc : {rowCnt, lowestCol(colunas_s)};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anyAcc <= 1'b0;
      selAcc <= 6'd0;
    end else if (frameEnd) begin
      anyAcc <= 1'b0;
      selAcc <= 6'd0;
    end else if (sampleTick) begin
      anyAcc <= anyNow;
      selAcc <= selNow;
    end
  end

`ifdef SCANNER_MULTI_ERR_EN
  logic multiAcc;
  logic multiNow;

  assign multiNow = multiAcc | (anyAcc & rowHit) | ((colunas_s & (colunas_s - 8'd1)) != 8'd0);
  assign anyEff   = anyNow & ~multiNow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      multiAcc      <= 1'b0;
      erro_multipla <= 1'b0;
    end else begin
      erro_multipla <= frameEnd & multiNow;
      if (frameEnd)        multiAcc <= 1'b0;
      else if (sampleTick) multiAcc <= multiNow;
    end
  end
`else
  assign anyEff = anyNow;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SCAN;
      cand  <= 6'd0;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cand  <= candNext;
      cnt   <= cntNext;
    end
  end

  assign cntInc = cnt + 4'd1;

  always_comb begin
    stateNext = state;
    candNext  = cand;
    cntNext   = cnt;
    case (state)
      SCAN: begin
        if (frameEnd && anyEff) begin
          candNext  = selNow;
          cntNext   = 4'd1;
          stateNext = (DEB <= 4'd1) ? EMIT : CONFIRM;
        end
      end
      CONFIRM: begin
        if (frameEnd) begin
          if (!anyEff) begin
            stateNext = SCAN;
            cntNext   = 4'd0;
          end else if (selNow == cand) begin
            if (cntInc >= DEB) begin
              cntNext   = DEB;
              stateNext = EMIT;
            end else begin
              cntNext = cntInc;
            end
          end else begin
            candNext = selNow;
            cntNext  = 4'd1;
          end
        end
      end
      EMIT: stateNext = WAIT_REL;
      WAIT_REL: begin
        if (frameEnd && !anyEff) begin
          stateNext = SCAN;
          cntNext   = 4'd0;
        end
      end
      default: stateNext = SCAN;
    endcase
  end

  // Coordinates load on the edge entering EMIT so they are valid alongside the strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogadaFileira <= 4'd0;
      jogadaColuna  <= 4'd0;
    end else if (stateNext == EMIT && state != EMIT) begin
      jogadaFileira <= {1'b0, candNext[5:3]};
      jogadaColuna  <= {1'b0, candNext[2:0]};
    end
  end

  assign temJogada = (state == EMIT);

  always_comb begin
    db_estado = {2'b00, state};
`ifdef SCANNER_MULTI_ERR_EN
    if (erro_multipla) db_estado = 4'd4;
`endif
  end

endmodule

// File: tb/tb_chess_board_scanner.sv
// Bench for chess_board_scanner: emulates the key matrix and checks against a frame-level move model.
module tb_chess_board_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  colA, colB, linhaA, linhaB;
  logic [3:0]  filA, colCA, dbA, filB, colCB, dbB;
  logic        temA, temB;
`ifdef SCANNER_MULTI_ERR_EN
  logic        erroA, erroB;
`endif
  logic [63:0] boardA = 64'd0;
  logic [63:0] boardB = 64'd0;

  always #5 clock = ~clock;

  function automatic logic [7:0] rowBits(input logic [63:0] b, input logic [7:0] sel);
    rowBits = 8'd0;
    for (int r = 0; r < 8; r++) if (sel[r]) rowBits = rowBits | b[r*8 +: 8];
  endfunction

  assign colA = rowBits(boardA, linhaA);
  assign colB = rowBits(boardB, linhaB);

  chess_board_scanner dutA (
    .clock(clock), .reset(reset), .colunas(colA), .linha_sel(linhaA),
    .jogadaFileira(filA), .jogadaColuna(colCA), .temJogada(temA),
`ifdef SCANNER_MULTI_ERR_EN
    .erro_multipla(erroA),
`endif
    .db_estado(dbA)
  );

  chess_board_scanner #(.SCAN_DIV(3), .DEBOUNCE(1)) dutB (
    .clock(clock), .reset(reset), .colunas(colB), .linha_sel(linhaB),
    .jogadaFileira(filB), .jogadaColuna(colCB), .temJogada(temB),
`ifdef SCANNER_MULTI_ERR_EN
    .erro_multipla(erroB),
`endif
    .db_estado(dbB)
  );

  int vec = 0, miss = 0;
  int which, SD, D, F, edges;
  int streak, lastSel, locked;
  logic [2:0] expRow, expColm;
  int pulses, pulseEdge, cycMismatch, erroPulses;
  string firstDiff;
  logic [7:0] obsLinha;
  logic [3:0] obsFil, obsCol, obsDb;
  logic obsTem, obsErro;

  function automatic logic [63:0] key(input int r, input int c);
    logic [63:0] one;
    one = 64'd1;
    return one << (r * 8 + c);
  endfunction

  task automatic set_dut(input int w);
    which = w;
    SD = (w != 0) ? 3 : 4;
    D  = (w != 0) ? 1 : 2;
    F  = 8 * SD;
  endtask

  task automatic observe();
    obsErro = 1'b0;
    if (which == 0) begin
      obsLinha = linhaA; obsFil = filA; obsCol = colCA; obsDb = dbA; obsTem = temA;
`ifdef SCANNER_MULTI_ERR_EN
      obsErro = erroA;
`endif
    end else begin
      obsLinha = linhaB; obsFil = filB; obsCol = colCB; obsDb = dbB; obsTem = temB;
`ifdef SCANNER_MULTI_ERR_EN
      obsErro = erroB;
`endif
    end
  endtask

  task automatic model_reset();
    streak = 0; locked = 0; lastSel = -1; expRow = 3'd0; expColm = 3'd0;
  endtask

  task automatic clear_stats();
    pulses = 0; pulseEdge = -1; cycMismatch = 0; erroPulses = 0; firstDiff = "";
  endtask

  task automatic do_reset();
    reset = 1'b1;
    boardA = 64'd0;
    boardB = 64'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    edges = 0;
    model_reset();
  endtask

  // Whole-frame view: a move is the same lowest-index key seen in D consecutive frames,
  // and nothing new is accepted until the board has been empty for one frame.
  task automatic model_frame(input logic [63:0] b, output bit emit, output bit multi);
    int n, low;
    n = $countones(b);
    low = -1;
    for (int i = 63; i >= 0; i--) if (b[i]) low = i;
    emit = 1'b0;
    multi = 1'b0;
`ifdef SCANNER_MULTI_ERR_EN
    multi = (n >= 2);
`endif
    if (n == 0 || multi) begin
      streak = 0;
      locked = 0;
    end else if (locked == 0) begin
      if (streak > 0 && low == lastSel) streak++;
      else begin
        streak = 1;
        lastSel = low;
      end
      if (streak >= D) begin
        emit = 1'b1;
        locked = 1;
        streak = 0;
        expRow = 3'(low / 8);
        expColm = 3'(low % 8);
      end
    end
  endtask

  task automatic tick(input logic [63:0] b);
    bit em, mu;
    logic [3:0] expDb;
    logic [7:0] expL;
    @(posedge clock);
    edges++;
    #1;
    em = 1'b0;
    mu = 1'b0;
    if (edges % F == 0) model_frame(b, em, mu);
    observe();
    expDb = em ? 4'd2 : (locked != 0) ? 4'd3 : (streak > 0) ? 4'd1 : 4'd0;
    if (mu) expDb = 4'd4;
    expL = 8'h01 << ((edges / SD) % 8);
    if (obsTem === 1'b1) begin
      pulses++;
      pulseEdge = edges;
    end
    if (obsErro === 1'b1) erroPulses++;
    if (obsTem !== em || obsFil !== {1'b0, expRow} || obsCol !== {1'b0, expColm} ||
        obsLinha !== expL || obsDb !== expDb || obsErro !== mu) begin
      if (cycMismatch == 0)
        firstDiff = $sformatf("edge %0d tem=%b/%b fil=%0d/%0d col=%0d/%0d linha=%h/%h db=%0d/%0d",
                              edges, obsTem, em, obsFil, expRow, obsCol, expColm, obsLinha, expL, obsDb, expDb);
      cycMismatch++;
    end
  endtask

  task automatic run_frames(input int n, input logic [63:0] b);
    if (which == 0) boardA = b; else boardB = b;
    repeat (n * F) tick(b);
  endtask

  task automatic run_cycles(input int n, input logic [63:0] b);
    repeat (n) tick(b);
  endtask

  task automatic test_reset();
    set_dut(0);
    reset = 1'b1;
    @(negedge clock);
    observe();
    vec++; if (obsLinha !== 8'h01) begin miss++; $display("FAIL reset_linhaA got %h want 01", obsLinha); end
    vec++; if (obsTem !== 1'b0) begin miss++; $display("FAIL reset_temA got %b want 0", obsTem); end
    vec++; if (obsDb !== 4'd0) begin miss++; $display("FAIL reset_dbA got %0d want 0", obsDb); end
    vec++; if (obsFil !== 4'd0 || obsCol !== 4'd0) begin miss++; $display("FAIL reset_coordsA got %0d,%0d want 0,0", obsFil, obsCol); end
    set_dut(1);
    observe();
    vec++; if (obsLinha !== 8'h01 || obsTem !== 1'b0) begin miss++; $display("FAIL reset_B got linha=%h tem=%b want 01 0", obsLinha, obsTem); end
  endtask

  task automatic test_single_press();
    set_dut(0); do_reset(); clear_stats();
    run_frames(3, key(5, 2));
    run_frames(2, 64'd0);
    vec++; if (cycMismatch !== 0) begin miss++; $display("FAIL single_model mismatches=%0d first: %s", cycMismatch, firstDiff); end
    vec++; if (pulses !== 1) begin miss++; $display("FAIL single_pulses got %0d want 1", pulses); end
    vec++; if (pulseEdge !== 64) begin miss++; $display("FAIL single_when got edge %0d want 64", pulseEdge); end
    vec++; if (obsFil !== 4'd5 || obsCol !== 4'd2) begin miss++; $display("FAIL single_coords got %0d,%0d want 5,2", obsFil, obsCol); end
  endtask

  task automatic test_short_press();
    set_dut(0); do_reset(); clear_stats();
    run_frames(1, key(1, 7));
    vec++; if (obsDb !== 4'd1) begin miss++; $display("FAIL short_confirm got db %0d want 1", obsDb); end
    run_frames(1, 64'd0);
    vec++; if (obsDb !== 4'd0) begin miss++; $display("FAIL short_back_scan got db %0d want 0", obsDb); end
    vec++; if (pulses !== 0 || cycMismatch !== 0) begin miss++; $display("FAIL short_nopulse got pulses=%0d mism=%0d want 0 0 %s", pulses, cycMismatch, firstDiff); end
  endtask

  task automatic test_two_keys();
    set_dut(0); do_reset(); clear_stats();
    run_frames(3, key(3, 0) | key(6, 4));
    run_frames(1, 64'd0);
    vec++; if (cycMismatch !== 0) begin miss++; $display("FAIL two_model mismatches=%0d first: %s", cycMismatch, firstDiff); end
`ifdef SCANNER_MULTI_ERR_EN
    vec++; if (pulses !== 0) begin miss++; $display("FAIL two_pulses got %0d want 0", pulses); end
    vec++; if (erroPulses !== 3) begin miss++; $display("FAIL two_erro got %0d want 3", erroPulses); end
`else
    vec++; if (pulses !== 1) begin miss++; $display("FAIL two_pulses got %0d want 1", pulses); end
    vec++; if (obsFil !== 4'd3 || obsCol !== 4'd0) begin miss++; $display("FAIL two_coords got %0d,%0d want 3,0", obsFil, obsCol); end
`endif
  endtask

  task automatic test_back_to_back();
    set_dut(0); do_reset(); clear_stats();
    run_frames(7, key(0, 0));
    vec++; if (pulses !== 1 || obsDb !== 4'd3) begin miss++; $display("FAIL b2b_held got pulses=%0d db=%0d want 1 3", pulses, obsDb); end
    run_frames(1, 64'd0);
    run_frames(2, key(7, 7));
    vec++; if (pulses !== 2) begin miss++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    vec++; if (pulseEdge !== 320) begin miss++; $display("FAIL b2b_when got edge %0d want 320", pulseEdge); end
    vec++; if (obsFil !== 4'd7 || obsCol !== 4'd7) begin miss++; $display("FAIL b2b_coords got %0d,%0d want 7,7", obsFil, obsCol); end
    vec++; if (cycMismatch !== 0) begin miss++; $display("FAIL b2b_model mismatches=%0d first: %s", cycMismatch, firstDiff); end
  endtask

  task automatic test_reset_mid_frame();
    set_dut(0); do_reset(); clear_stats();
    run_frames(2, key(6, 1));
    run_frames(1, 64'd0);
    run_frames(1, key(2, 3));
    vec++; if (obsDb !== 4'd1 || obsFil !== 4'd6) begin miss++; $display("FAIL mid_pre got db=%0d fil=%0d want 1 6", obsDb, obsFil); end
    run_cycles(10, key(2, 3));
    reset = 1'b1;
    #1;
    observe();
    vec++; if (obsLinha !== 8'h01) begin miss++; $display("FAIL mid_linha got %h want 01", obsLinha); end
    vec++; if (obsTem !== 1'b0 || obsDb !== 4'd0) begin miss++; $display("FAIL mid_state got tem=%b db=%0d want 0 0", obsTem, obsDb); end
    vec++; if (obsFil !== 4'd0 || obsCol !== 4'd0) begin miss++; $display("FAIL mid_coords got %0d,%0d want 0,0", obsFil, obsCol); end
    do_reset(); clear_stats();
    run_frames(1, key(2, 3));
    vec++; if (pulses !== 0) begin miss++; $display("FAIL mid_early got %0d pulses want 0", pulses); end
    run_frames(1, key(2, 3));
    vec++; if (pulses !== 1 || pulseEdge !== 64) begin miss++; $display("FAIL mid_emit got pulses=%0d edge=%0d want 1 64", pulses, pulseEdge); end
    vec++; if (obsFil !== 4'd2 || obsCol !== 4'd3 || cycMismatch !== 0) begin miss++; $display("FAIL mid_coords2 got %0d,%0d mism=%0d want 2,3 0", obsFil, obsCol, cycMismatch); end
  endtask

  task automatic test_fast_params();
    set_dut(1); do_reset(); clear_stats();
    run_frames(1, key(4, 4));
    vec++; if (pulses !== 1 || pulseEdge !== 24) begin miss++; $display("FAIL fast_emit got pulses=%0d edge=%0d want 1 24", pulses, pulseEdge); end
    vec++; if (obsFil !== 4'd4 || obsCol !== 4'd4) begin miss++; $display("FAIL fast_coords got %0d,%0d want 4,4", obsFil, obsCol); end
    run_frames(1, 64'd0);
    vec++; if (cycMismatch !== 0) begin miss++; $display("FAIL fast_model mismatches=%0d first: %s", cycMismatch, firstDiff); end
  endtask

  task automatic test_random(input int w, input int frames);
    logic [63:0] prev, b, one;
    one = 64'd1;
    prev = 64'd0;
    set_dut(w); do_reset();
    for (int k = 0; k < frames; k++) begin
      case ($urandom_range(0, 5))
        0:       b = 64'd0;
        1, 2:    b = prev;
        3:       b = one << $urandom_range(0, 63);
        4:       b = (one << $urandom_range(0, 63)) | (one << $urandom_range(0, 63));
        default: b = prev | (one << $urandom_range(0, 63));
      endcase
      prev = b;
      clear_stats();
      run_frames(1, b);
      vec++; if (cycMismatch !== 0) begin miss++; $display("FAIL random_dut%0d frame %0d board=%h mism=%0d first: %s", w, k, b, cycMismatch, firstDiff); end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_short_press();
    test_two_keys();
    test_back_to_back();
    test_reset_mid_frame();
    test_fast_params();
    test_random(0, 40);
    test_random(1, 40);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/chess_board_scanner.md
Name: chess_board_scanner

Overview:
- Front end of the move-input path: drives an 8x8 push-button or reed-switch board matrix and produces the move that the game core consumes.
- Scans the matrix row by row, synchronizes and debounces the column returns, and confirms one pressed square.
- Presents the square as row/column codes with a one-cycle temJogada strobe.
- Sits between the board pins and the game datapath's jogadaFileira/jogadaColuna/temJogada inputs.

Parameters:
- SCAN_DIV, 4, clocks spent driving each row before sampling; legal range 3..65535.
- DEBOUNCE, 2, consecutive complete frames in which the same square must be the selected press before it is emitted; legal range 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- colunas  in  8  raw column returns, active-high; bit c is column c.
- linha_sel  out  8  one-hot, active-high row drive; bit r drives row r.
- jogadaFileira  out  4  confirmed row, 0..7, upper bit always 0.
- jogadaColuna  out  4  confirmed column, 0..7 (0 = file A), upper bit always 0.
- temJogada  out  1  one-cycle strobe; coordinates are valid on this cycle and held afterwards.
- db_estado  out  4  FSM state code for the 7-seg debug display.

Behaviour:
- Reset values:
  - linha_sel = 8'b0000_0001; row counter = 0; divider = 0.
  - jogadaFileira = 0, jogadaColuna = 0, temJogada = 0.
  - FSM in SCAN, db_estado = 0; debounce count = 0; synchronizer flops = 0.
- Synchronizer: colunas passes through a 2-flop synchronizer (colunas_s).
- Row timing:
  - The divider counts 0..SCAN_DIV-1 while linha_sel drives the current row.
  - At count SCAN_DIV-1, colunas_s is sampled for that row, the row counter advances (7 wraps to 0), and linha_sel rotates left with wrap.
  - One frame = 8*SCAN_DIV clocks.
- Per-frame evaluation, accumulated across the 8 samples:
  - any = at least one sampled bit is 1.
  - sel = first pressed square in scan order: lowest row, then lowest column.
  - frame_end = the sample cycle of row 7.
- FSM states:
  - SCAN (code 0): at frame_end, if any, latch cand = sel, set cnt = 1, go to CONFIRM; if cnt reaches DEBOUNCE at that point (DEBOUNCE = 1), go to EMIT instead.
  - CONFIRM (code 1): at frame_end:
    - any and sel == cand: cnt++; when cnt == DEBOUNCE, go to EMIT.
    - any and sel != cand: cand = sel, cnt = 1.
    - !any: go to SCAN, cnt = 0.
  - EMIT (code 2): lasts exactly one clock. temJogada = 1; jogadaFileira/jogadaColuna load cand on the edge entering EMIT. Next state is WAIT_REL.
  - WAIT_REL (code 3): at frame_end, if !any, go to SCAN; otherwise stay. No new move is emitted while any key remains pressed.
- Latency: temJogada asserts the clock immediately after the frame_end edge that completes the DEBOUNCE-th matching frame.
- Coordinates hold their last value until the next EMIT.
- Scanning never stops; the divider and linha_sel run in every state.
- Reset mid-frame: aborts immediately (asynchronous); the partial frame is discarded and scanning restarts at row 0 with count 0.
- Widths: cnt is 4 bits and saturates at DEBOUNCE; no arithmetic overflow is possible.

Optional Feature:
- Macro: SCANNER_MULTI_ERR_EN.
- Defined:
  - Adds output erro_multipla (1 bit, reset 0).
  - A frame with two or more pressed squares is treated as !any for FSM purposes.
  - erro_multipla pulses high for one clock after that frame_end, in every state.
  - db_estado shows code 4 during that cycle.
- Not defined: no extra port; the lowest-index-priority rule above applies.

Test Plan:
- Defaults (frame = 32 clocks). Hold colunas[2]=1 while only row 5 is driven (square r5,c2) for 3 frames, then release -> one temJogada pulse with jogadaFileira=5, jogadaColuna=2, at the clock after the second frame_end; no second pulse.
- Press r1,c7 for 1 frame only, then release -> no temJogada; FSM returns to SCAN (db_estado=0).
- Press r3,c0 and r6,c4 together for 3 frames -> emits r3,c0. With SCANNER_MULTI_ERR_EN: no temJogada, and erro_multipla pulses once per frame.
- Emit r0,c0, keep it held for 5 frames, release for 1 frame, press r7,c7 for 2 frames -> exactly two pulses: (0,0), then (7,7).
- Assert reset mid-frame while in CONFIRM -> immediately linha_sel=8'h01, temJogada=0, db_estado=0, coordinates 0. After release, a held press needs the full 2 frames again.
- SCAN_DIV=3, DEBOUNCE=1. Press r4,c4 for 1 frame -> temJogada one clock after that frame_end (frame = 24 clocks), coordinates (4,4).
